// File: rtl/game_sequencer.sv
// game_sequencer: central game controller for the VGA Pacman design.
// Sequences IDLE/PLAY/DYING/RESPAWN/WIN/LOSE, tracks lives, derives a frame
// tick from vCount and issues serialised one-cycle move enables so that pacman
// and each ghost get their own cycle on the shared maze/wall lookup.
// Optional feature: define GAME_SEQ_PAUSE_EN to add the pause port and the
// PAUSED state (encoding 6); without it that encoding is unreachable.
module game_sequencer #(
  parameter int         NUM_GHOSTS      = 4,
  parameter int         FRAMES_PER_STEP = 4,
  parameter int         LIVES           = 3,
  parameter int         DEATH_FRAMES    = 60,
  parameter logic [9:0] ACTIVE_V        = 10'd480
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  ack,
  input  logic [9:0]            vCount,
  input  logic                  collision,
  input  logic                  food_empty,
  output logic                  pac_step,
  output logic [NUM_GHOSTS-1:0] ghost_step,
  output logic                  respawn,
  output logic [1:0]            lives,
  output logic [2:0]            state,
  output logic                  win,
  output logic                  lose
`ifdef GAME_SEQ_PAUSE_EN
  ,
  input  logic                  pause
`endif
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_PLAY    = 3'd1;
  localparam logic [2:0] S_DYING   = 3'd2;
  localparam logic [2:0] S_RESPAWN = 3'd3;
  localparam logic [2:0] S_WIN     = 3'd4;
  localparam logic [2:0] S_LOSE    = 3'd5;
  localparam logic [2:0] S_PAUSED  = 3'd6;

  logic [9:0]            v_q;
  logic                  at_active_q;
  logic                  tick;
  logic [2:0]            state_d;
  logic [3:0]            step_cnt;
  logic [5:0]            death_cnt;
  logic                  busy;
  logic [2:0]            burst_idx;
  logic                  launch;
  logic [NUM_GHOSTS-1:0] ghost_d;

  // Register vCount, then edge-detect the ACTIVE_V line into a one-cycle tick.
  // NOTE: state is updated with non-blocking (<=) so every register samples
  // the pre-edge values; blocking (=) here would create ordering races.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v_q         <= '0;
      at_active_q <= 1'b0;
      tick        <= 1'b0;
    end else begin
      v_q         <= vCount;
      at_active_q <= (v_q == ACTIVE_V);
      tick        <= (v_q == ACTIVE_V) && !at_active_q;
    end
  end

  // Next-state decode for the game FSM.
  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:    if (start) state_d = S_PLAY;
      S_PLAY: begin
        if (food_empty)     state_d = S_WIN;
        else if (collision) state_d = S_DYING;
`ifdef GAME_SEQ_PAUSE_EN
        else if (pause)     state_d = S_PAUSED;
`endif
      end
      S_DYING: begin
        if (tick && (death_cnt == 6'(DEATH_FRAMES - 1)))
          state_d = (lives == 2'd0) ? S_LOSE : S_RESPAWN;
      end
      S_RESPAWN: state_d = S_PLAY;
      S_WIN, S_LOSE: if (ack || start) state_d = S_IDLE;
`ifdef GAME_SEQ_PAUSE_EN
      S_PAUSED:  if (pause) state_d = S_PLAY;
`endif
      default:   state_d = S_IDLE;
    endcase
  end

  // A burst launches only on the tick that completes a step while staying in PLAY.
  assign launch = (state == S_PLAY) && (state_d == S_PLAY) && tick &&
                  (step_cnt == 4'(FRAMES_PER_STEP - 1));

  // Ghost enable for the current burst slot; suppressed as soon as PLAY is left.
  always_comb begin
    ghost_d = '0;
    for (int i = 0; i < NUM_GHOSTS; i++)
      ghost_d[i] = busy && (burst_idx == 3'(i + 1)) && (state_d == S_PLAY);
  end

  // FSM state, lives and the phase-level outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      lives   <= 2'(LIVES);
      respawn <= 1'b0;
      win     <= 1'b0;
      lose    <= 1'b0;
    end else begin
      state   <= state_d;
      win     <= (state_d == S_WIN);
      lose    <= (state_d == S_LOSE);
      respawn <= (state_d == S_RESPAWN) ||
                 ((state_d == S_IDLE) && (state != S_IDLE));
      if ((state_d == S_IDLE) && (state != S_IDLE))
        lives <= 2'(LIVES);
      else if ((state == S_PLAY) && (state_d == S_DYING) && (lives != 2'd0))
        lives <= lives - 2'd1;
    end
  end

  // Frame counters: step counter runs in PLAY, death counter runs in DYING.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      step_cnt  <= '0;
      death_cnt <= '0;
    end else begin
      // Resuming from PAUSED keeps the held step count.
      if (((state == S_IDLE) || (state == S_RESPAWN)) && (state_d == S_PLAY))
        step_cnt <= '0;
      else if ((state == S_PLAY) && (state_d == S_PLAY) && tick)
        step_cnt <= launch ? 4'd0 : step_cnt + 4'd1;

      if ((state != S_DYING) && (state_d == S_DYING))
        death_cnt <= '0;
      else if ((state == S_DYING) && tick)
        death_cnt <= death_cnt + 6'd1;
    end
  end

  // Step burst sequencer: pac_step first, then one ghost per cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy       <= 1'b0;
      burst_idx  <= '0;
      pac_step   <= 1'b0;
      ghost_step <= '0;
    end else begin
      pac_step   <= launch;
      ghost_step <= ghost_d;
      if (state_d != S_PLAY) begin
        busy      <= 1'b0;
        burst_idx <= '0;
      end else if (launch) begin
        busy      <= 1'b1;
        burst_idx <= 3'd1;
      end else if (busy) begin
        if (burst_idx == 3'(NUM_GHOSTS)) begin
          busy      <= 1'b0;
          burst_idx <= '0;
        end else begin
          burst_idx <= burst_idx + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed testbench for game_sequencer with default parameters
// (NUM_GHOSTS=4, FRAMES_PER_STEP=4, LIVES=3, DEATH_FRAMES=60).
// Define GAME_SEQ_PAUSE_EN to also exercise the pause feature.
module tb_game_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       ack = 1'b0;
  logic [9:0] vCount = 10'd0;
  logic       collision = 1'b0;
  logic       food_empty = 1'b0;
  logic       pac_step;
  logic [3:0] ghost_step;
  logic       respawn;
  logic [1:0] lives;
  logic [2:0] state;
  logic       win;
  logic       lose;
`ifdef GAME_SEQ_PAUSE_EN
  logic       pause = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int pac_cnt = 0;
  int ghost_cnt = 0;
  int resp_cnt = 0;
  bit overlap = 1'b0;

  game_sequencer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .ack        (ack),
    .vCount     (vCount),
    .collision  (collision),
    .food_empty (food_empty),
    .pac_step   (pac_step),
    .ghost_step (ghost_step),
    .respawn    (respawn),
    .lives      (lives),
    .state      (state),
    .win        (win),
    .lose       (lose)
`ifdef GAME_SEQ_PAUSE_EN
    ,
    .pause      (pause)
`endif
  );

  always #5 clk = ~clk;

  // Pulse bookkeeping sampled mid-cycle.
  always @(negedge clk) begin
    if (pac_step) pac_cnt++;
    ghost_cnt += $countones(ghost_step);
    if (respawn) resp_cnt++;
    if ($countones({pac_step, ghost_step}) > 1) overlap = 1'b1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One frame of 8 cycles: vCount sits on ACTIVE_V for one cycle.
  task automatic frame();
    vCount = 10'd480;
    step();
    vCount = 10'd0;
    repeat (7) step();
  endtask

  task automatic test_reset();
    repeat (2) step();
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
    checks++; if (lives !== 2'd3) begin errors++; $display("FAIL reset_lives: got %0d expected 3", lives); end
    checks++; if ({pac_step, ghost_step, respawn, win, lose} !== 8'd0) begin errors++;
      $display("FAIL reset_outputs: got %b expected 0", {pac_step, ghost_step, respawn, win, lose}); end
    reset_n = 1'b1;
    step();
  endtask

  // Final frame of a step: checks pac_step then each ghost in turn.
  task automatic burst_frame(input string tag);
    vCount = 10'd480;
    step();
    vCount = 10'd0;
    step();
    step();
    checks++; if ({pac_step, ghost_step} !== 5'b10000) begin errors++;
      $display("FAIL %s_pac: got %b expected 10000", tag, {pac_step, ghost_step}); end
    for (int k = 0; k < 4; k++) begin
      logic [4:0] exp_v;
      exp_v = 5'b00001 << k;
      step();
      checks++; if ({pac_step, ghost_step} !== exp_v) begin errors++;
        $display("FAIL %s_ghost%0d: got %b expected %b", tag, k, {pac_step, ghost_step}, exp_v); end
    end
    step();
    checks++; if ({pac_step, ghost_step} !== 5'b00000) begin errors++;
      $display("FAIL %s_end: got %b expected 00000", tag, {pac_step, ghost_step}); end
  endtask

  task automatic test_start();
    start = 1'b1;
    step();
    start = 1'b0;
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL start_state: got %0d expected 1", state); end
    repeat (3) frame();
    checks++; if (pac_cnt !== 0) begin errors++; $display("FAIL start_early_pac: got %0d expected 0", pac_cnt); end
    burst_frame("step1");
    repeat (3) frame();
    checks++; if (pac_cnt !== 1) begin errors++; $display("FAIL start_mid_pac: got %0d expected 1", pac_cnt); end
    burst_frame("step2");
  endtask

  task automatic test_collision();
    int p0, g0, r0;
    collision = 1'b1;
    step();
    collision = 1'b0;
    checks++; if (state !== 3'd2) begin errors++; $display("FAIL coll_state: got %0d expected 2", state); end
    checks++; if (lives !== 2'd2) begin errors++; $display("FAIL coll_lives: got %0d expected 2", lives); end
    p0 = pac_cnt; g0 = ghost_cnt; r0 = resp_cnt;
    repeat (59) frame();
    checks++; if (state !== 3'd2) begin errors++; $display("FAIL dying_hold: got %0d expected 2", state); end
    vCount = 10'd480;
    step();
    vCount = 10'd0;
    step();
    step();
    checks++; if ({state, respawn} !== {3'd3, 1'b1}) begin errors++;
      $display("FAIL respawn_on: got state %0d respawn %b expected 3 1", state, respawn); end
    step();
    checks++; if ({state, respawn} !== {3'd1, 1'b0}) begin errors++;
      $display("FAIL respawn_off: got state %0d respawn %b expected 1 0", state, respawn); end
    repeat (4) step();
    checks++; if ((pac_cnt - p0) + (ghost_cnt - g0) !== 0) begin errors++;
      $display("FAIL dying_steps: got %0d expected 0", (pac_cnt - p0) + (ghost_cnt - g0)); end
    checks++; if (resp_cnt - r0 !== 1) begin errors++; $display("FAIL respawn_count: got %0d expected 1", resp_cnt - r0); end
  endtask

  task automatic test_last_life();
    int r0;
    collision = 1'b1;
    step();
    collision = 1'b0;
    checks++; if (lives !== 2'd1) begin errors++; $display("FAIL life2_lives: got %0d expected 1", lives); end
    repeat (60) frame();
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL life2_back: got %0d expected 1", state); end
    collision = 1'b1;
    step();
    collision = 1'b0;
    checks++; if ({state, lives} !== {3'd2, 2'd0}) begin errors++;
      $display("FAIL life1_dying: got state %0d lives %0d expected 2 0", state, lives); end
    r0 = resp_cnt;
    repeat (60) frame();
    checks++; if ({state, lose, win, lives} !== {3'd5, 1'b1, 1'b0, 2'd0}) begin errors++;
      $display("FAIL lose: got state %0d lose %b win %b lives %0d expected 5 1 0 0", state, lose, win, lives); end
    checks++; if (resp_cnt - r0 !== 0) begin errors++; $display("FAIL lose_respawn: got %0d expected 0", resp_cnt - r0); end
    ack = 1'b1;
    step();
    ack = 1'b0;
    checks++; if ({state, respawn, lives, lose} !== {3'd0, 1'b1, 2'd3, 1'b0}) begin errors++;
      $display("FAIL ack_idle: got state %0d respawn %b lives %0d lose %b expected 0 1 3 0", state, respawn, lives, lose); end
    step();
    checks++; if (respawn !== 1'b0) begin errors++; $display("FAIL ack_respawn_width: got %b expected 0", respawn); end
  endtask

  task automatic test_simultaneous();
    start = 1'b1;
    step();
    start = 1'b0;
    food_empty = 1'b1;
    collision = 1'b1;
    step();
    food_empty = 1'b0;
    collision = 1'b0;
    checks++; if ({state, win, lose, lives} !== {3'd4, 1'b1, 1'b0, 2'd3}) begin errors++;
      $display("FAIL win_priority: got state %0d win %b lose %b lives %0d expected 4 1 0 3", state, win, lose, lives); end
    step();
    checks++; if (state !== 3'd4) begin errors++; $display("FAIL win_hold: got %0d expected 4", state); end
    start = 1'b1;
    step();
    start = 1'b0;
    checks++; if ({state, respawn, win} !== {3'd0, 1'b1, 1'b0}) begin errors++;
      $display("FAIL start_as_ack: got state %0d respawn %b win %b expected 0 1 0", state, respawn, win); end
  endtask

  task automatic test_abort();
    int g0;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) frame();
    vCount = 10'd480;
    step();
    vCount = 10'd0;
    step();
    step();
    checks++; if (pac_step !== 1'b1) begin errors++; $display("FAIL abort_pac: got %b expected 1", pac_step); end
    g0 = ghost_cnt;
    collision = 1'b1;
    step();
    collision = 1'b0;
    checks++; if ({state, ghost_step} !== {3'd2, 4'b0000}) begin errors++;
      $display("FAIL abort_same_cycle: got state %0d ghost %b expected 2 0000", state, ghost_step); end
    repeat (5) step();
    checks++; if (ghost_cnt - g0 !== 0) begin errors++; $display("FAIL abort_ghosts: got %0d expected 0", ghost_cnt - g0); end
  endtask

  task automatic test_reset_mid();
    int p0, r0;
    repeat (3) frame();
    checks++; if ({state, lives} !== {3'd2, 2'd2}) begin errors++;
      $display("FAIL pre_reset: got state %0d lives %0d expected 2 2", state, lives); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if ({state, lives, pac_step, ghost_step, respawn, win, lose} !== {3'd0, 2'd3, 8'd0}) begin errors++;
      $display("FAIL async_reset: got state %0d lives %0d outs %b expected 0 3 0", state, lives,
               {pac_step, ghost_step, respawn, win, lose}); end
    repeat (3) step();
    reset_n = 1'b1;
    p0 = pac_cnt; r0 = resp_cnt;
    repeat (6) frame();
    checks++; if ((pac_cnt - p0) + (resp_cnt - r0) !== 0 || state !== 3'd0) begin errors++;
      $display("FAIL post_reset_quiet: got pulses %0d state %0d expected 0 0", (pac_cnt - p0) + (resp_cnt - r0), state); end
  endtask

`ifdef GAME_SEQ_PAUSE_EN
  task automatic test_pause();
    int p0;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (2) frame();
    pause = 1'b1;
    step();
    pause = 1'b0;
    checks++; if (state !== 3'd6) begin errors++; $display("FAIL pause_enter: got %0d expected 6", state); end
    p0 = pac_cnt;
    repeat (10) frame();
    checks++; if (pac_cnt - p0 !== 0) begin errors++; $display("FAIL pause_steps: got %0d expected 0", pac_cnt - p0); end
    pause = 1'b1;
    step();
    pause = 1'b0;
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL pause_exit: got %0d expected 1", state); end
    frame();
    checks++; if (pac_cnt - p0 !== 0) begin errors++; $display("FAIL resume_held: got %0d expected 0", pac_cnt - p0); end
    frame();
    checks++; if (pac_cnt - p0 !== 1) begin errors++; $display("FAIL resume_step: got %0d expected 1", pac_cnt - p0); end
  endtask
`endif

  task automatic test_no_overlap();
    checks++; if (overlap !== 1'b0) begin errors++; $display("FAIL step_overlap: got %b expected 0", overlap); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_collision();
    test_last_life();
    test_simultaneous();
    test_abort();
    test_reset_mid();
`ifdef GAME_SEQ_PAUSE_EN
    test_pause();
`endif
    test_no_overlap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
